// File: rtl/scpu_mem_pkg.sv
// ============================================================================
// scpu_mem_pkg : shared state encoding and defaults for the loadable
//                sCPU instruction memory.             Revision: 1.0
// ============================================================================
`default_nettype none

package scpu_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_LOAD  = 2'd2
  } mem_state_e;

  // Wide enough for any practical instruction width; users slice what they need.
  localparam logic [63:0] NOP_WORD = 64'd0;

endpackage : scpu_mem_pkg

`default_nettype wire

// File: rtl/instr_ram_array.sv
// ============================================================================
// instr_ram_array : single-write, registered-read storage array (no reset).
//                                                      Revision: 1.0
// ============================================================================
`default_nettype none

module instr_ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : instr_ram_array

`default_nettype wire

// File: rtl/loadable_instruction_memory.sv
// ============================================================================
// loadable_instruction_memory : self-clearing, stream-loadable instruction
//                               store with registered fetch.  Revision: 1.0
// ============================================================================
`default_nettype none

module loadable_instruction_memory
  import scpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   load_words,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  mem_ready
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [DATA_WIDTH-1:0] NOP       = NOP_WORD[DATA_WIDTH-1:0];

  mem_state_e            state_q,      state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q,    clr_ptr_d;
  logic [ADDR_WIDTH-1:0] wptr_q,       wptr_d;
  logic [ADDR_WIDTH:0]   load_words_q, load_words_d;
  logic                  load_done_q,  load_done_d;
  logic                  load_error_q, load_error_d;
  logic                  instr_valid_q, instr_valid_d;
  // The array has no reset, so the output reads NOP until the first real fetch.
  logic                  instr_zero_q, instr_zero_d;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wptr_d        = wptr_q;
    load_words_d  = load_words_q;
    load_done_d   = 1'b0;
    load_error_d  = load_error_q;
    instr_valid_d = 1'b0;
    instr_zero_d  = instr_zero_q;
    ram_we        = 1'b0;
    ram_waddr     = wptr_q;
    ram_wdata     = load_data;
    ram_re        = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr_q;
        ram_wdata = NOP;
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        // A fetch coinciding with load_start still reads the pre-load contents.
        if (fetch_en) begin
          ram_re        = 1'b1;
          instr_valid_d = 1'b1;
          instr_zero_d  = 1'b0;
        end
        if (load_start) begin
          state_d      = ST_LOAD;
          wptr_d       = '0;
          load_words_d = '0;
          load_error_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          ram_we       = 1'b1;
          wptr_d       = wptr_q + PTR_ONE;
          load_words_d = load_words_q + CNT_ONE;
          if (load_last) begin
            state_d     = ST_READY;
            load_done_d = 1'b1;
          end else if (wptr_q == LAST_ADDR) begin
            state_d      = ST_READY;
            load_error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      wptr_q        <= '0;
      load_words_q  <= '0;
      load_done_q   <= 1'b0;
      load_error_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_zero_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wptr_q        <= wptr_d;
      load_words_q  <= load_words_d;
      load_done_q   <= load_done_d;
      load_error_q  <= load_error_d;
      instr_valid_q <= instr_valid_d;
      instr_zero_q  <= instr_zero_d;
    end
  end

  instr_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_addr),
    .rdata (ram_rdata)
  );

  assign load_ready  = (state_q == ST_LOAD);
  assign mem_ready   = (state_q == ST_READY);
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;
  assign load_words  = load_words_q;
  assign instr_valid = instr_valid_q;
  assign instruction = instr_zero_q ? NOP : ram_rdata;

endmodule : loadable_instruction_memory

`default_nettype wire

// File: tb/tb_loadable_instruction_memory.sv
// ============================================================================
// tb_loadable_instruction_memory : scoreboard bench for the loadable
//                                  instruction memory.    Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_loadable_instruction_memory;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   load_words;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] instruction;
  logic          instr_valid;
  logic          mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wbuf  [$];

  loadable_instruction_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_error  (load_error),
    .load_words  (load_words),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every instr_valid must match the oldest outstanding fetch.
  always @(posedge clk) begin
    #1;
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) check_value("unexpected_instr_valid", instr_valid, 0);
      else check_value("fetch_data", instruction, exp_q.pop_front());
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic check_reset_outputs();
    check_value("rst_instruction", instruction, 0);
    check_value("rst_instr_valid", instr_valid, 0);
    check_value("rst_load_ready",  load_ready, 0);
    check_value("rst_load_done",   load_done, 0);
    check_value("rst_load_error",  load_error, 0);
    check_value("rst_load_words",  load_words, 0);
    check_value("rst_mem_ready",   mem_ready, 0);
  endtask

  task automatic wait_ready();
    int cnt = 0;
    while (mem_ready !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    check_value("clear_cycles", cnt, DEPTH);
  endtask

  task automatic fetch_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      fetch_en   = 1'b1;
      fetch_addr = a[AW-1:0];
      exp_q.push_back(model[a]);
      step();
    end
    fetch_en = 1'b0;
    step();
    step();
    check_value("instr_valid_idle", instr_valid, 0);
    check_value("instr_hold", instruction, model[hi]);
    check_value("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic begin_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_value("load_ready_on_start", load_ready, 1);
    check_value("mem_ready_in_load",  mem_ready, 0);
    check_value("load_words_cleared", load_words, 0);
    check_value("load_error_cleared", load_error, 0);
  endtask

  // Streams wbuf; stops on refusal, on the last word, or after DEPTH writes.
  task automatic stream(input bit use_last, input bit stall, output int accepted);
    int  i = 0;
    int  wp = 0;
    bit  acc;
    bit  is_last;
    while (i < wbuf.size()) begin
      if (stall && i > 0) begin
        load_valid = 1'b0;
        step();
        check_value("done_during_stall", load_done, 0);
      end
      is_last    = use_last && (i == wbuf.size() - 1);
      load_valid = 1'b1;
      load_data  = wbuf[i];
      load_last  = is_last;
      acc        = load_ready;
      step();
      if (!acc) break;
      model[wp] = wbuf[i];
      check_value("load_done_pulse", load_done, is_last ? 1 : 0);
      wp++;
      i++;
      if (is_last || wp == DEPTH) break;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    accepted   = wp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_clear();

    // 1: reset, clear sequence, everything reads NOP
    step();
    step();
    check_reset_outputs();
    rst = 1'b0;
    wait_ready();
    fetch_range(0, 15);

    // 2: normal 8-word load
    wbuf = '{8'h8A, 8'h90, 8'hA0, 8'hB1, 8'h17, 8'h29, 8'hD1, 8'hDF};
    begin_load();
    stream(1'b1, 1'b0, n);
    check_value("s2_accepted", n, 8);
    step();
    check_value("s2_done_one_cycle", load_done, 0);
    check_value("s2_load_words", load_words, 8);
    check_value("s2_load_error", load_error, 0);
    check_value("s2_mem_ready", mem_ready, 1);
    fetch_range(0, 8);

    // 3: same program with stalls between words
    model_clear();
    begin_load();
    stream(1'b1, 1'b1, n);
    check_value("s3_accepted", n, 8);
    step();
    check_value("s3_load_words", load_words, 8);
    fetch_range(0, 8);

    // 5: fetch and load_start together; fetch sees pre-load contents
    fetch_en   = 1'b1;
    fetch_addr = 4'd3;
    load_start = 1'b1;
    exp_q.push_back(model[3]);
    step();
    fetch_en   = 1'b0;
    load_start = 1'b0;
    check_value("s5_instr_valid", instr_valid, 1);
    check_value("s5_load_ready", load_ready, 1);
    check_value("s5_mem_ready", mem_ready, 0);
    step();

    // 4: 17-word stream without load_last overflows
    wbuf.delete();
    for (int i = 0; i < 17; i++) wbuf.push_back(8'h40 + 8'(i));
    stream(1'b0, 1'b0, n);
    check_value("s4_accepted", n, 16);
    check_value("s4_load_error", load_error, 1);
    check_value("s4_load_words", load_words, 16);
    check_value("s4_no_done", load_done, 0);
    load_valid = 1'b1;
    load_data  = wbuf[16];
    check_value("s4_word17_refused", load_ready, 0);
    step();
    load_valid = 1'b0;
    check_value("s4_error_sticky", load_error, 1);
    fetch_range(15, 15);

    // 6: reset in the middle of a load
    wbuf = '{8'h11, 8'h22, 8'h33};
    begin_load();
    stream(1'b0, 1'b0, n);
    check_value("s6_accepted", n, 3);
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;
    model_clear();
    wait_ready();
    check_value("s6_load_words", load_words, 0);
    fetch_range(0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_loadable_instruction_memory

`default_nettype wire

// File: doc/loadable_instruction_memory.md
Name: loadable_instruction_memory

Overview:
Parametrised, run-time loadable instruction store for the sCPU, replacing the fixed 16x8 hard-wired program mux.
- After reset, clears itself to NOP (all-zero words).
- Accepts a program over a valid/ready load stream.
- Serves registered instruction fetches to the control unit.
- Sits between the PC/control unit and an external program loader (test bench or UART bootloader).

Parameters:
DATA_WIDTH, 8, instruction word width in bits
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH (localparam, not overridable)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
load_start  input  1  request to begin a program load (sampled in READY only)
load_valid  input  1  load_data is valid this cycle
load_data  input  DATA_WIDTH  instruction word to store
load_last  input  1  qualifies the final word of the program (with load_valid)
load_ready  output  1  block accepts a load word this cycle
load_done  output  1  one-cycle pulse: load ended normally
load_error  output  1  sticky: last load overflowed DEPTH; cleared by next load_start or rst
load_words  output  ADDR_WIDTH+1  words written by the most recent load
fetch_en  input  1  fetch request
fetch_addr  input  ADDR_WIDTH  fetch address (PC)
instruction  output  DATA_WIDTH  fetched word, registered
instr_valid  output  1  instruction updated this cycle
mem_ready  output  1  block is in READY and fetches are serviced

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=CLEAR, clear pointer=0, write pointer=0
  - instruction=0, instr_valid=0, load_ready=0, load_done=0, load_error=0, load_words=0, mem_ready=0
  - rst has priority over every other input.
- States: CLEAR, READY, LOAD. Encoding comes from the package.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle, then clr_ptr++.
  - After writing DEPTH-1, moves to READY. CLEAR therefore lasts exactly DEPTH cycles, and mem_ready first reads 1 in cycle DEPTH after rst deasserts.
  - All inputs are ignored.
- READY:
  - mem_ready=1, load_ready=0.
  - fetch_en=1: next cycle instruction=mem[fetch_addr] and instr_valid=1. Latency is 1 cycle, one fetch per cycle, back-to-back allowed.
  - fetch_en=0: next cycle instr_valid=0 and instruction holds its value.
  - load_start=1: move to LOAD; write pointer=0, load_words=0, load_error=0.
  - load_start and fetch_en in the same cycle: the fetch is still serviced from pre-load contents, and the state goes to LOAD.
- LOAD:
  - load_ready=1 combinationally (state==LOAD), mem_ready=0. fetch_en and load_start are ignored; instr_valid=0.
  - Transfer occurs when load_valid && load_ready: mem[wptr]=load_data, wptr++, load_words++.
  - Transfer with load_last=1: go to READY and pulse load_done=1 for exactly the next cycle.
  - Transfer into address DEPTH-1 with load_last=0: the word is written, load_error=1, go to READY, no load_done. Following words are refused because load_ready=0.
  - A transfer at DEPTH-1 with load_last=1 is a normal completion: load_words=DEPTH, no error.
  - load_valid=0: no change. Stalls of any length are legal.
  - Words not rewritten keep their previous contents (NOP after CLEAR).
- rst mid-LOAD or mid-fetch: returns to CLEAR and the whole array is re-zeroed; a partial program is not preserved.
- Write-then-read of the same address in different cycles returns the new data. No same-cycle read/write conflict is possible, because fetch and load are exclusive by state.
- Widths: wptr is ADDR_WIDTH bits and wraps naturally. Overflow is detected by wptr==DEPTH-1, not by wrap.

Decomposition:
- Package scpu_mem_pkg:
  - state encoding localparams CLEAR/READY/LOAD
  - NOP_WORD (all-zero)
  - default DATA_WIDTH/ADDR_WIDTH
- Sub-module instr_ram_array(DATA_WIDTH, ADDR_WIDTH):
  - single write port (we, waddr, wdata)
  - registered read port (re, raddr, rdata)
  - no reset on the array
- The top holds the FSM, pointers, flags and output muxing, and drives the array write port from CLEAR or LOAD.

Test Plan:
1. Reset then idle, 20 cycles:
   - mem_ready rises exactly 16 cycles after rst falls.
   - Fetching addresses 0..15 returns 0x00 with instr_valid one cycle after each fetch_en.
2. Load 8 words 0x8A,0x90,0xA0,0xB1,0x17,0x29,0xD1,0xDF, last on 0xDF:
   - load_done pulses once, load_words=8, load_error=0.
   - Fetching addresses 0..7 back-to-back returns those words in order; address 8 returns 0x00.
3. Same 8-word load with load_valid de-asserted every other cycle:
   - Identical memory contents, and load_done only after the 8th transfer.
4. 17-word stream with no load_last:
   - 16 words written, load_error=1, load_words=16, 17th word refused (load_ready=0).
   - Fetching address 15 returns the 16th word.
5. load_start and fetch_en(addr 3) in the same cycle after scenario 2:
   - instruction=0xB1 with instr_valid=1, then state LOAD with load_ready=1.
6. rst asserted after 3 load words:
   - CLEAR rerun, mem_ready after 16 cycles, all addresses read 0x00, load_words=0.
